// File: rtl/daq_pkg.sv
// Shared constants, FSM state encoding and frame sizing for the DAQ frame packetizer.
package daq_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CONV,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_HDR,
    ST_RD,
    ST_EMIT_MSB,
    ST_EMIT_LSB,
    ST_GAP
  } state_t;

  function automatic int unsigned frame_len(input int unsigned num_adc, input int unsigned num_ch);
    return 3 + 2 * num_adc * num_ch;
  endfunction

endpackage

// File: rtl/daq_conv_timer.sv
// Conversion period timer and CONVST low-pulse shaper.
module daq_conv_timer #(
  parameter int unsigned CLK_DIV  = 500,
  parameter int unsigned CONV_LOW = 50
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic start_i,
  output logic tick_o,
  output logic convst_o,
  output logic conv_done_o
);

  localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PW = (CONV_LOW > 1) ? $clog2(CONV_LOW) : 1;

  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          convst_q, convst_d;

  always_comb begin
    timer_d = '0;
    if (enable_i && timer_q != TW'(CLK_DIV - 1)) timer_d = timer_q + 1'b1;

    convst_d = convst_q;
    pulse_d  = pulse_q;
    if (start_i) begin
      convst_d = 1'b0;
      pulse_d  = PW'(CONV_LOW - 1);
    end else if (!convst_q) begin
      if (pulse_q == '0) convst_d = 1'b1;
      else               pulse_d  = pulse_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      timer_q  <= '0;
      pulse_q  <= '0;
      convst_q <= 1'b1;
    end else begin
      timer_q  <= timer_d;
      pulse_q  <= pulse_d;
      convst_q <= convst_d;
    end
  end

  assign tick_o      = enable_i && (timer_q == '0);
  assign convst_o    = convst_q;
  assign conv_done_o = !convst_q && (pulse_q == '0);

endmodule

// File: rtl/daq_frame_packetizer.sv
// Multi-ADC AD7606 readout: periodic conversion, BUSY wait, sequential channel reads and
// framed byte stream into a FIFO write port with back-pressure, drop and overrun counters.
module daq_frame_packetizer
  import daq_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 500,
  parameter int unsigned CONV_LOW = 50,
  parameter int unsigned NUM_ADC  = 4,
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned RD_LOW   = 2,
  parameter int unsigned RD_HIGH  = 2,
  parameter int unsigned BUSY_TO  = 400
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [2:0]         os_sel_i,
  output logic [2:0]         adc_os_o,
  output logic               adc_convst_o,
  input  logic               adc_busy_i,
  output logic [NUM_ADC-1:0] adc_cs_n_o,
  output logic               adc_rd_n_o,
  input  logic [15:0]        adc_db_i,
  input  logic               adc_frstdata_i,
  output logic [7:0]         fifo_data_o,
  output logic               fifo_wrreq_o,
  input  logic               fifo_wrfull_i,
  output logic [15:0]        drop_cnt_o,
  output logic [15:0]        ovr_cnt_o,
  output logic               err_o
);

  localparam logic [15:0] BUSY_LIMIT   = 16'(BUSY_TO);
  localparam logic [7:0]  RD_LOW_LAST  = 8'(RD_LOW - 1);
  localparam logic [7:0]  RD_HIGH_LAST = 8'(RD_HIGH - 1);
  localparam logic [2:0]  ADC_LAST     = 3'(NUM_ADC - 1);
  localparam logic [2:0]  CH_LAST      = 3'(NUM_CH - 1);

  state_t      state_q, state_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] fseq_q, fseq_d;
  logic [2:0]  os_q, os_d;
  logic [2:0]  adc_q, adc_d;
  logic [2:0]  ch_q, ch_d;
  logic [7:0]  phase_q, phase_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] sample_q, sample_d;
  logic [1:0]  hdr_q, hdr_d;
  logic [15:0] drop_q, drop_d;
  logic [15:0] ovr_q, ovr_d;
  logic        err_q, err_d;

  logic tick, start, conv_done, cs_active, last_sample;

  daq_conv_timer #(
    .CLK_DIV  (CLK_DIV),
    .CONV_LOW (CONV_LOW)
  ) u_timer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .start_i     (start),
    .tick_o      (tick),
    .convst_o    (adc_convst_o),
    .conv_done_o (conv_done)
  );

  assign last_sample = (adc_q == ADC_LAST) && (ch_q == CH_LAST);
  assign cs_active   = (state_q == ST_RD) || (state_q == ST_EMIT_MSB) ||
                       (state_q == ST_EMIT_LSB) || (state_q == ST_GAP);

  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    fseq_d       = fseq_q;
    os_d         = os_q;
    adc_d        = adc_q;
    ch_d         = ch_q;
    phase_d      = phase_q;
    wait_d       = wait_q;
    sample_d     = sample_q;
    hdr_d        = hdr_q;
    drop_d       = drop_q;
    ovr_d        = ovr_q;
    err_d        = err_q;
    start        = 1'b0;
    fifo_wrreq_o = 1'b0;
    fifo_data_o  = '0;
    adc_rd_n_o   = 1'b1;

    if (tick && state_q != ST_IDLE && ovr_q != '1) ovr_d = ovr_q + 16'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          start   = 1'b1;
          os_d    = os_sel_i;
          fseq_d  = seq_q;
          seq_d   = seq_q + 16'd1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          wait_d  = '0;
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI, ST_WAIT_LO: begin
        wait_d = wait_q + 16'd1;
        if (wait_q == BUSY_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (state_q == ST_WAIT_HI && adc_busy_i) begin
          state_d = ST_WAIT_LO;
        end else if (state_q == ST_WAIT_LO && !adc_busy_i) begin
          hdr_d   = '0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        unique case (hdr_q)
          2'd0:    fifo_data_o = SYNC_BYTE;
          2'd1:    fifo_data_o = fseq_q[15:8];
          default: fifo_data_o = fseq_q[7:0];
        endcase
        // Full on the first header cycle drops the whole frame; later fulls just stall.
        if (!fifo_wrfull_i) begin
          fifo_wrreq_o = 1'b1;
          if (hdr_q == 2'd2) begin
            adc_d   = '0;
            ch_d    = '0;
            phase_d = '0;
            state_d = ST_GAP;
          end else begin
            hdr_d = hdr_q + 2'd1;
          end
        end else if (hdr_q == 2'd0) begin
          if (drop_q != '1) drop_d = drop_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        adc_rd_n_o = 1'b0;
        if (phase_q == RD_LOW_LAST) begin
          sample_d = adc_db_i;
          if (ch_q == '0 && !adc_frstdata_i) err_d = 1'b1;
          state_d = ST_EMIT_MSB;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      ST_EMIT_MSB: begin
        fifo_data_o = sample_q[15:8];
        if (!fifo_wrfull_i) begin
          fifo_wrreq_o = 1'b1;
          state_d      = ST_EMIT_LSB;
        end
      end
      ST_EMIT_LSB: begin
        fifo_data_o = sample_q[7:0];
        if (!fifo_wrfull_i) begin
          fifo_wrreq_o = 1'b1;
          if (last_sample) begin
            state_d = ST_IDLE;
          end else begin
            if (ch_q == CH_LAST) begin
              ch_d  = '0;
              adc_d = adc_q + 3'd1;
            end else begin
              ch_d = ch_q + 3'd1;
            end
            phase_d = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        // Chip select for the upcoming read settles here, while RD_N is still high.
        if (phase_q == RD_HIGH_LAST) begin
          phase_d = '0;
          state_d = ST_RD;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    adc_cs_n_o = '1;
    if (cs_active) begin
      for (int unsigned i = 0; i < NUM_ADC; i++) begin
        if (adc_q == 3'(i)) adc_cs_n_o[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      seq_q    <= '0;
      fseq_q   <= '0;
      os_q     <= '0;
      adc_q    <= '0;
      ch_q     <= '0;
      phase_q  <= '0;
      wait_q   <= '0;
      sample_q <= '0;
      hdr_q    <= '0;
      drop_q   <= '0;
      ovr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      fseq_q   <= fseq_d;
      os_q     <= os_d;
      adc_q    <= adc_d;
      ch_q     <= ch_d;
      phase_q  <= phase_d;
      wait_q   <= wait_d;
      sample_q <= sample_d;
      hdr_q    <= hdr_d;
      drop_q   <= drop_d;
      ovr_q    <= ovr_d;
      err_q    <= err_d;
    end
  end

  assign adc_os_o   = os_q;
  assign drop_cnt_o = drop_q;
  assign ovr_cnt_o  = ovr_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_daq_frame_packetizer.sv
// Directed bench: 2 ADCs x 2 channels with a ramping ADC model, plus a short-period
// instance whose BUSY never rises, used to provoke conversion overruns.
module tb_daq_frame_packetizer;
  import daq_pkg::*;

  localparam int unsigned NA   = 2;
  localparam int unsigned NC   = 2;
  localparam int unsigned FLEN = frame_len(NA, NC);

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        enable, enable2;
  logic [2:0]  os_sel;
  logic [2:0]  adc_os;
  logic        convst, busy, rd_n, frst, wrreq, full, err;
  logic [1:0]  cs_n;
  logic [15:0] db, drop_cnt, ovr_cnt;
  logic [7:0]  data;

  logic [2:0]  os2;
  logic        convst2, rd2, wrreq2, err2;
  logic [0:0]  cs2;
  logic [7:0]  data2;
  logic [15:0] drop2, ovr2;

  always #5 clk = ~clk;

  daq_frame_packetizer #(
    .CLK_DIV (100), .CONV_LOW (3), .NUM_ADC (NA), .NUM_CH (NC),
    .RD_LOW (2), .RD_HIGH (2), .BUSY_TO (20)
  ) dut (
    .clk_i (clk), .reset_i (reset_i), .enable_i (enable), .os_sel_i (os_sel),
    .adc_os_o (adc_os), .adc_convst_o (convst), .adc_busy_i (busy), .adc_cs_n_o (cs_n),
    .adc_rd_n_o (rd_n), .adc_db_i (db), .adc_frstdata_i (frst), .fifo_data_o (data),
    .fifo_wrreq_o (wrreq), .fifo_wrfull_i (full), .drop_cnt_o (drop_cnt),
    .ovr_cnt_o (ovr_cnt), .err_o (err)
  );

  daq_frame_packetizer #(
    .CLK_DIV (20), .CONV_LOW (3), .NUM_ADC (1), .NUM_CH (1),
    .RD_LOW (2), .RD_HIGH (2), .BUSY_TO (40)
  ) dut_ovr (
    .clk_i (clk), .reset_i (reset_i), .enable_i (enable2), .os_sel_i (3'd0),
    .adc_os_o (os2), .adc_convst_o (convst2), .adc_busy_i (1'b0), .adc_cs_n_o (cs2),
    .adc_rd_n_o (rd2), .adc_db_i (16'h0000), .adc_frstdata_i (1'b0), .fifo_data_o (data2),
    .fifo_wrreq_o (wrreq2), .fifo_wrfull_i (1'b0), .drop_cnt_o (drop2),
    .ovr_cnt_o (ovr2), .err_o (err2)
  );

  // ADC model: BUSY for 5 cycles after CONVST rises; data ramps with reads since CONVST.
  logic       busy_en, bad_frst, cv_prev, rd_prev;
  logic [2:0] bcnt;
  logic [3:0] rdcnt;

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      bcnt <= '0; cv_prev <= 1'b1; rd_prev <= 1'b1; rdcnt <= '0;
    end else begin
      cv_prev <= convst;
      rd_prev <= rd_n;
      if (!cv_prev && convst && busy_en) bcnt <= 3'd5;
      else if (bcnt != 0)                bcnt <= bcnt - 3'd1;
      if (!convst)               rdcnt <= '0;
      else if (!rd_prev && rd_n) rdcnt <= rdcnt + 4'd1;
    end
  end

  assign busy = (bcnt != 0);
  assign frst = (rdcnt[0] == 1'b0) && !(bad_frst && cs_n == 2'b01);
  always_comb begin
    case (cs_n)
      2'b10:   db = 16'h1234 + 16'h1111 * {12'd0, rdcnt};
      2'b01:   db = 16'hA000 + 16'h0102 * {12'd0, rdcnt};
      default: db = 16'hDEAD;
    endcase
  end

  // FIFO-side monitor and bus protocol watch.
  logic [7:0] cap[$];
  int         viol = 0;
  logic [1:0] cs_prev = 2'b11;
  always @(negedge clk) begin
    if (wrreq && !full) cap.push_back(data);
    if (wrreq && full) viol++;
    if (cs_n == 2'b00) viol++;
    if (cs_n != cs_prev && !rd_n) viol++;
    cs_prev = cs_n;
  end

  int nvec = 0;
  int nmis = 0;
  int ncyc = 0;

  logic [7:0] exp_dat [8] = '{8'h12, 8'h34, 8'h23, 8'h45, 8'hA2, 8'h04, 8'hA3, 8'h06};

  typedef struct {
    logic        hdr_full;
    logic        stall;
    logic        busy_ok;
    logic        dis_after;
    logic [2:0]  os;
    logic [15:0] seq;
    int          nbytes;
    logic [15:0] drop;
    logic        err;
  } vec_t;
  vec_t tv [7];

  task automatic step();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_fall(input string nm);
    for (int k = 0; k < 250 && convst !== 1'b0; k++) step();
    if (convst !== 1'b0) begin
      nvec++;
      nmis++;
      $display("FAIL %s: convst still %0b after 250 cycles, expected 0", nm, convst);
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] seq, input int nbytes);
    logic [7:0] e;
    chk({tag, "_nbytes"}, 32'(cap.size()), 32'(nbytes));
    for (int j = 0; j < nbytes && j < cap.size(); j++) begin
      if (j == 0)      e = 8'hA5;
      else if (j == 1) e = seq[15:8];
      else if (j == 2) e = seq[7:0];
      else             e = exp_dat[j-3];
      chk($sformatf("%s_byte%0d", tag, j), 32'(cap[j]), 32'(e));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_convst"}, 32'(convst), 32'd1);
    chk({tag, "_cs_n"},   32'(cs_n),   32'h3);
    chk({tag, "_rd_n"},   32'(rd_n),   32'd1);
    chk({tag, "_os"},     32'(adc_os), 32'd0);
    chk({tag, "_wrreq"},  32'(wrreq),  32'd0);
    chk({tag, "_data"},   32'(data),   32'd0);
    chk({tag, "_drop"},   32'(drop_cnt), 32'd0);
    chk({tag, "_ovr"},    32'(ovr_cnt), 32'd0);
    chk({tag, "_err"},    32'(err),    32'd0);
  endtask

  initial begin
    //           hdr_full stall busy_ok dis   os     seq       nbytes     drop   err
    tv[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0000, FLEN, 16'd0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0001, FLEN, 16'd0, 1'b0};
    tv[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 16'h0002, 0,    16'd1, 1'b0};
    tv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0003, FLEN, 16'd1, 1'b0};
    tv[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h0004, 0,    16'd1, 1'b1};
    tv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 16'h0005, FLEN, 16'd1, 1'b1};
    tv[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 16'h0006, FLEN, 16'd1, 1'b1};

    enable = 1'b0; enable2 = 1'b0; full = 1'b0; os_sel = 3'd0;
    busy_en = 1'b1; bad_frst = 1'b0;
    #1 reset_i = 1'b1;
    repeat (2) step();
    check_reset("por");
    reset_i = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      os_sel  = tv[i].os;
      busy_en = tv[i].busy_ok;
      if (tv[i].hdr_full) full = 1'b1;
      cap.delete();
      enable = 1'b1;
      wait_fall($sformatf("v%0d_start", i));
      ncyc = 0;
      if (tv[i].dis_after) enable = 1'b0;
      if (tv[i].stall) begin
        while (cap.size() < 4 && ncyc < 40) step();
        full = 1'b1;
        repeat (5) step();
        full = 1'b0;
      end
      if (!tv[i].busy_ok) begin
        while (ncyc < 20) step();
        chk($sformatf("v%0d_err_before_timeout", i), 32'(err), 32'd0);
        while (ncyc < 30) step();
        chk($sformatf("v%0d_err_after_timeout", i), 32'(err), 32'd1);
      end
      while (ncyc < 55) step();
      full = 1'b0;
      check_frame($sformatf("v%0d", i), tv[i].seq, tv[i].nbytes);
      chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(tv[i].drop));
      chk($sformatf("v%0d_err", i),  32'(err),      32'(tv[i].err));
      chk($sformatf("v%0d_os", i),   32'(adc_os),   32'(tv[i].os));
      chk($sformatf("v%0d_ovr", i),  32'(ovr_cnt),  32'd0);
    end

    cap.delete();
    repeat (150) step();
    chk("no_frame_after_disable", 32'(cap.size()), 32'd0);

    enable2 = 1'b1;
    repeat (50) step();
    chk("ovr_after_2_missed", 32'(ovr2), 32'd2);
    repeat (80) step();
    chk("ovr_after_4_missed", 32'(ovr2), 32'd4);
    chk("ovr_inst_timeout_err", 32'(err2), 32'd1);
    enable2 = 1'b0;

    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_reset("rst2");
    bad_frst = 1'b1;
    cap.delete();
    enable = 1'b1;
    wait_fall("frst_start");
    ncyc = 0;
    while (ncyc < 55) step();
    check_frame("frst", 16'h0000, FLEN);
    chk("frst_err", 32'(err), 32'd1);

    bad_frst = 1'b0;
    cap.delete();
    wait_fall("midrst_start");
    ncyc = 0;
    while (cap.size() < 5 && ncyc < 60) step();
    chk("midrst_cs_active", 32'(cs_n), 32'h2);
    reset_i = 1'b1;
    #1;
    check_reset("midrst");
    step();
    reset_i = 1'b0;
    enable  = 1'b0;
    step();

    chk("protocol_violations", 32'(viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
